// File: rtl/sigmoid.sv
// FP16 logistic sigmoid using the PLAN piecewise-linear approximation (shift-and-add only).
// Four-stage datapath sequenced by a request/valid handshake FSM.
//
// state     | meaning
// IDLE      | waiting for add_activation, captures neuron_val on exit
// CONVERT   | |x| -> unsigned 3.16 fixed point, saturation detect
// COMPUTE   | piecewise-linear segment evaluation and symmetry fold (1.21 fixed)
// NORMALIZE | leading-one detect and round-to-nearest-even into FP16
// DONE      | outputs loaded on the first edge here, held until request drops
module sigmoid (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [15:0] neuron_val,
    input  logic        add_activation,
    output logic        valid,
    output logic [15:0] result
);

    typedef enum logic [2:0] {IDLE, CONVERT, COMPUTE, NORMALIZE, DONE} state_t;

    state_t      state, state_nxt;
    logic        cap_en, cvt_en, cmp_en, nrm_en, done_st;

    logic [15:0] x_q;
    logic [18:0] ax_q;
    logic        sat_q;
    logic [21:0] y_q;
    logic [15:0] fp_q;

    logic [4:0]  x_exp;
    logic [18:0] m_ext, ax_c;
    logic        sat_c, nan_c;
    logic [21:0] y_pos, y_c;
    logic [4:0]  msb, sh;
    logic [21:0] mant, rem, half;
    logic        rnd;
    logic [15:0] fp_c;

    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (add_activation) state_nxt = CONVERT;
            CONVERT:   state_nxt = add_activation ? COMPUTE   : IDLE;
            COMPUTE:   state_nxt = add_activation ? NORMALIZE : IDLE;
            NORMALIZE: state_nxt = add_activation ? DONE      : IDLE;
            DONE:      if (!add_activation) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cap_en  = (state == IDLE) && add_activation;
        cvt_en  = (state == CONVERT);
        cmp_en  = (state == COMPUTE);
        nrm_en  = (state == NORMALIZE);
        done_st = (state == DONE);
    end

    // Exponent 18+ is already >= 8 (covers Inf); exponent 0 reads as zero.
    always_comb begin
        x_exp = x_q[14:10];
        m_ext = {8'd0, 1'b1, x_q[9:0]};
        if (x_exp == 5'd0)       ax_c = 19'd0;
        else if (x_exp >= 5'd9)  ax_c = m_ext << (x_exp - 5'd9);
        else                     ax_c = m_ext >> (5'd9 - x_exp);
        sat_c = (x_exp >= 5'd18) || (ax_c >= 19'd327680);
        nan_c = (x_exp == 5'd31) && (x_q[9:0] != 10'd0);
    end

    // ax_q is |x| in units of 2^-16, so |x|>>5 in units of 2^-21 is ax_q itself.
    always_comb begin
        if (sat_q)                      y_pos = 22'h200000;
        else if (ax_q >= 19'd155648)    y_pos = {3'd0, ax_q} + 22'd1769472;
        else if (ax_q >= 19'd65536)     y_pos = {1'b0, ax_q, 2'b00} + 22'd1310720;
        else                            y_pos = {ax_q, 3'b000} + 22'd1048576;
        y_c = x_q[15] ? (22'h200000 - y_pos) : y_pos;
    end

    always_comb begin
        msb = 5'd0;
        for (int i = 0; i < 22; i++)
            if (y_q[i]) msb = i[4:0];
        sh   = 5'd0;
        rem  = 22'd0;
        half = 22'd0;
        rnd  = 1'b0;
        if (msb >= 5'd10) begin
            sh   = msb - 5'd10;
            mant = y_q >> sh;
            rem  = y_q & ((22'd1 << sh) - 22'd1);
            half = (22'd1 << sh) >> 1;
            rnd  = (sh != 5'd0) && ((rem > half) || ((rem == half) && mant[0]));
        end else begin
            mant = y_q << (5'd10 - msb);
        end
        // A mantissa carry out of the rounding add rolls into the exponent field.
        if (nan_c)            fp_c = 16'h7E00;
        else if (y_q[21])     fp_c = 16'h3C00;
        else if (msb < 5'd7)  fp_c = 16'h0000;
        else                  fp_c = {1'b0, msb - 5'd6, mant[9:0]} + {15'd0, rnd};
    end

    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            x_q   <= 16'd0;
            ax_q  <= 19'd0;
            sat_q <= 1'b0;
            y_q   <= 22'd0;
            fp_q  <= 16'd0;
        end else begin
            if (cap_en) x_q <= neuron_val;
            if (cvt_en) begin
                ax_q  <= ax_c;
                sat_q <= sat_c;
            end
            if (cmp_en) y_q  <= y_c;
            if (nrm_en) fp_q <= fp_c;
        end
    end

    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            valid  <= 1'b0;
            result <= 16'h0000;
        end else begin
            if (done_st && add_activation && !valid) result <= fp_q;
            valid <= done_st && add_activation;
        end
    end

endmodule

// File: tb/tb_sigmoid.sv
// Bench for sigmoid: directed handshake/segment/special cases plus a randomized
// sweep over [-8, 8] against a real-arithmetic reference model.
module tb_sigmoid;

    logic        clk = 1'b0;
    logic        reset_b;
    logic [15:0] neuron_val;
    logic        add_activation;
    logic        valid;
    logic [15:0] result;

    int total = 0;
    int bad   = 0;

    sigmoid dut (
        .clk            (clk),
        .reset_b        (reset_b),
        .neuron_val     (neuron_val),
        .add_activation (add_activation),
        .valid          (valid),
        .result         (result)
    );

    always #5 clk = ~clk;

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp16_to_real(input logic [15:0] h);
        real r;
        if (h[14:10] == 5'd0) r = 0.0;
        else r = (1024.0 + h[9:0]) * pow2(int'(h[14:10]) - 25);
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] ref_sig(input logic [15:0] x);
        real a, af, y, m, fl, fr;
        int  e, fi;
        logic [4:0] be;
        logic [9:0] bm;
        if (x[14:10] == 5'd31) begin
            if (x[9:0] != 10'd0) return 16'h7E00;
            return x[15] ? 16'h0000 : 16'h3C00;
        end
        a  = (x[14:10] == 5'd0) ? 0.0 : (1024.0 + x[9:0]) * pow2(int'(x[14:10]) - 25);
        af = $floor(a * 65536.0) / 65536.0;
        if (a >= 5.0)        y = 1.0;
        else if (af >= 2.375) y = af / 32.0 + 0.84375;
        else if (af >= 1.0)   y = af / 8.0 + 0.625;
        else                  y = af / 4.0 + 0.5;
        if (x[15]) y = 1.0 - y;
        if (y >= 1.0) return 16'h3C00;
        if (y < pow2(-14)) return 16'h0000;
        m = y;
        e = 0;
        while (m < 1.0) begin
            m = m * 2.0;
            e = e - 1;
        end
        m  = m * 1024.0;
        fl = $floor(m);
        fr = m - fl;
        fi = int'(fl);
        if (fr > 0.5 || (fr == 0.5 && (fi % 2) == 1)) fi = fi + 1;
        if (fi == 2048) begin
            fi = 1024;
            e  = e + 1;
        end
        be = 5'(e + 15);
        bm = 10'(fi - 1024);
        return {1'b0, be, bm};
    endfunction

    task automatic check(input logic [15:0] obs, input logic [15:0] exp_v, input string tag);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Full request/valid transaction; checks latency, result, and release behaviour.
    task automatic run_op(input logic [15:0] x, input logic [15:0] exp_r, input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        neuron_val     = x;
        add_activation = 1'b1;
        @(posedge clk);
        #2 neuron_val = 16'($urandom);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check(16'(lat), 16'd4, {tag, "_latency"});
        check(result, exp_r, {tag, "_result"});
        @(negedge clk);
        add_activation = 1'b0;
        @(posedge clk);
        #1;
        check({15'd0, valid}, 16'd0, {tag, "_valid_drop"});
        check(result, exp_r, {tag, "_result_hold"});
    endtask

    initial begin
        logic [15:0] x, r_exp, held;
        real xr, err;
        int  seen;

        reset_b        = 1'b1;
        neuron_val     = 16'h0000;
        add_activation = 1'b0;
        #23;
        check({15'd0, valid}, 16'd0, "reset_valid");
        check(result, 16'h0000, "reset_result");
        @(negedge clk);
        reset_b = 1'b0;

        run_op(16'h0000, 16'h3800, "zero");
        run_op(16'h3C00, 16'h3A00, "pos1");
        run_op(16'hBC00, 16'h3400, "neg1");
        run_op(16'h4000, 16'h3B00, "pos2");
        run_op(16'h4200, 16'h3B80, "pos3");
        run_op(16'h4600, 16'h3C00, "pos6");
        run_op(16'hC600, 16'h0000, "neg6");
        run_op(16'h7C00, 16'h3C00, "pinf");
        run_op(16'hFC00, 16'h0000, "ninf");
        run_op(16'h7E00, 16'h7E00, "nan");
        run_op(16'h40C0, ref_sig(16'h40C0), "b2375");
        run_op(16'h40BF, ref_sig(16'h40BF), "b2375m");
        run_op(16'h4500, 16'h3C00, "b5");
        run_op(16'h44FF, ref_sig(16'h44FF), "b5m");
        run_op(16'h0001, 16'h3800, "subnorm");

        // Abort right after capture: no valid, result keeps the last value.
        run_op(16'h4200, 16'h3B80, "pre_abort");
        @(negedge clk);
        neuron_val     = 16'h4600;
        add_activation = 1'b1;
        @(posedge clk);
        @(negedge clk);
        add_activation = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) seen = 1;
        end
        check(16'(seen), 16'd0, "abort_no_valid");
        check(result, 16'h3B80, "abort_result_hold");
        run_op(16'h3C00, 16'h3A00, "post_abort");

        // Reset while in COMPUTE.
        @(negedge clk);
        neuron_val     = 16'h4000;
        add_activation = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 reset_b = 1'b1;
        #1;
        check({15'd0, valid}, 16'd0, "midreset_valid");
        check(result, 16'h0000, "midreset_result");
        @(negedge clk);
        add_activation = 1'b0;
        reset_b        = 1'b0;
        run_op(16'hBC00, 16'h3400, "post_reset");

        // Randomized sweep over [-8, 8].
        for (int n = 0; n < 2500; n++) begin
            x = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 16'h4800))};
            r_exp = ref_sig(x);
            run_op(x, r_exp, "sweep");
            xr  = fp16_to_real(x);
            err = fp16_to_real(result) - 1.0 / (1.0 + $exp(-xr));
            if (err < 0.0) err = -err;
            total++;
            assert (err < 0.02) else begin
                bad++;
                $error("FAIL sweep_abs_err: x=%h observed=%h err=%f limit=0.02", x, result, err);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
